evr_rx_phase_ctrl: RTL
======================

# evr_rx_phase_ctrl

Parametrised receive-phase controller for the EVR GTX receive path. It sits between the GTX RX channel and the comma bit-slide aligner, all on the recovered user clock. It repeatedly resets the GTX RX until the aligner reports the target bit-slide value, which fixes the recovered-clock phase. It qualifies the lock over a settle window, watches the link for loss of sync or excess encoding errors, and re-locks automatically. Retry, relock and failure status are reported to the event-receiver logic.

## Interface
- TARGET_SLIDE, 3: required aligner bit-slide value.
- SLIDE_W, 5: width of bit-slide input.
- RETRY_W, 10: width of retry and relock counters.
- MAX_RETRY, 1023: retries allowed before FAIL; must be ≤ 2^RETRY_W−1.
- RST_HOLD, 16: cycles rx_rst_o is held high per attempt; ≥1.
- LOCK_TIMEOUT, 65535: cycles allowed in WAIT_SYNC; ≥1.
- SETTLE_CYC, 1024: consecutive clean cycles needed before READY; ≥1.
- ERR_WIN, 256: length of the encoding-error window in READY; ≥1.
- ERR_LIMIT, 8: errors within one window that trigger a relock; ≥1.
- rx_clk_i  in  1  recovered user clock (BUFG'd RXRECCLK); single clock domain.
- rst_n_i  in  1  reset, asynchronous, active-low.
- enable_i  in  1  level; high runs the controller, low returns it to IDLE.
- serdes_ready_i  in  1  RX reset-done AND RX PLL lock.
- synced_i  in  1  aligner synced flag.
- bitslide_i  in  SLIDE_W  aligner bit-slide count; valid only while synced_i=1.
- enc_err_i  in  1  OR of disparity and not-in-table errors, this cycle.
- rx_rst_o  out  1  GTX RX reset request (GTXRXRESET) and aligner reset.
- ready_o  out  1  link phase-locked and qualified.
- fail_o  out  1  retry budget exhausted.
- retry_cnt_o  out  RETRY_W  attempts in the current lock sequence.
- relock_cnt_o  out  RETRY_W  relocks from READY since enable; saturates.
- state_o  out  3  current state encoding.

## Operation
- States and encodings: IDLE=0, RESET=1, WAIT_SYNC=2, CHECK=3, SETTLE=4, READY=5, FAIL=6. Encoding 7 is unused and recovers to IDLE.
- "Retry path":
  - If retry_cnt = MAX_RETRY, go to FAIL.
  - Otherwise increment retry_cnt and go to RESET.
- IDLE:
  - rx_rst_o=1.
  - Clears retry_cnt and relock_cnt.
  - Goes to RESET when enable_i=1.
- RESET:
  - rx_rst_o=1 for exactly RST_HOLD cycles, then WAIT_SYNC.
  - The timer is cleared on entry.
- WAIT_SYNC:
  - rx_rst_o=0.
  - When serdes_ready_i & synced_i, go to CHECK.
  - Otherwise, on the LOCK_TIMEOUT-th cycle in the state, take the retry path.
- CHECK:
  - One cycle.
  - If bitslide_i = TARGET_SLIDE, go to SETTLE; else take the retry path.
  - The comparison zero-extends TARGET_SLIDE to SLIDE_W.
- SETTLE:
  - Each cycle must show serdes_ready_i=1, synced_i=1, bitslide_i=TARGET_SLIDE and enc_err_i=0.
  - Any violation takes the retry path.
  - After SETTLE_CYC clean cycles, go to READY.
- READY:
  - ready_o=1.
  - Free-running window counter of ERR_WIN cycles; the error counter clears at each window start.
  - Relock triggers:
    - serdes_ready_i=0;
    - synced_i=0;
    - bitslide_i ≠ TARGET_SLIDE;
    - the error counter reaching ERR_LIMIT within a window.
  - On a relock trigger:
    - relock_cnt increments, saturating at all-ones;
    - retry_cnt clears;
    - go to RESET.
- FAIL:
  - fail_o=1 and rx_rst_o=0.
  - retry_cnt holds at MAX_RETRY.
  - The state is held until enable_i=0.
- enable_i=0 in any state: go to IDLE on the next edge. This has priority over all other transitions.
- Simultaneous events:
  - In READY, if an error lands on the last window cycle and reaches ERR_LIMIT, relock occurs; the window restart does not mask it.
  - In WAIT_SYNC, if sync and timeout coincide, sync wins.

## Timing
- All outputs are registered and updated on the same edge as state_o.
- Reset values (asynchronous, while rst_n_i=0):
  - state_o=0, rx_rst_o=1, ready_o=0, fail_o=0;
  - retry_cnt_o=0, relock_cnt_o=0;
  - all internal counters 0.
- After rst_n_i is released with enable_i=1: RESET is entered at the 1st edge, and rx_rst_o stays 1 through RST_HOLD edges.
- Best-case enable to ready_o:
  - 1 (IDLE→RESET) + RST_HOLD + 1 (WAIT_SYNC→CHECK, sync already present) + 1 (CHECK→SETTLE) + SETTLE_CYC edges.
- Each failed attempt adds RST_HOLD plus the WAIT_SYNC dwell plus 1 cycle.
- ready_o drops on the edge that leaves READY. It never glitches high outside READY.
- Counters stop at their compare values; none wrap.

## Test plan
- Parameters RST_HOLD=4, SETTLE_CYC=8, LOCK_TIMEOUT=32, MAX_RETRY=3, ERR_WIN=16, ERR_LIMIT=2. Release reset with enable_i=1, synced and bitslide=3 present → rx_rst_o high 4 cycles, ready_o high on the 15th edge, retry_cnt_o=0.
- bitslide_i=5 for two attempts, then 3 → two RESET pulses each 4 cycles wide, retry_cnt_o=2, ready_o high afterwards.
- synced_i held at 0 → each WAIT_SYNC exits after 32 cycles; after 3 retries, fail_o=1, state_o=6, retry_cnt_o=3. enable_i low → state_o=0, rx_rst_o=1, fail_o=0.
- In READY, enc_err_i pulses at window cycles 3 and 9 → relock, relock_cnt_o=1, retry_cnt_o=0, rx_rst_o high 4 cycles. A single error per window → no relock.
- enc_err_i during SETTLE cycle 5 → retry_cnt_o increments and RESET is re-entered. rst_n_i asserted mid-SETTLE → all outputs take their reset values immediately, without a clock.

Source files
------------

// File: rtl/evr_rx_phase_ctrl.sv
// rtl/evr_rx_phase_ctrl.sv - GTX receive-phase lock controller with settle qualification and auto-relock
module evr_rx_phase_ctrl #(
    parameter int TARGET_SLIDE = 3,
    parameter int SLIDE_W      = 5,
    parameter int RETRY_W      = 10,
    parameter int MAX_RETRY    = 1023,
    parameter int RST_HOLD     = 16,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int SETTLE_CYC   = 1024,
    parameter int ERR_WIN      = 256,
    parameter int ERR_LIMIT    = 8
) (
    input  logic               rx_clk_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    input  logic               serdes_ready_i,
    input  logic               synced_i,
    input  logic [SLIDE_W-1:0] bitslide_i,
    input  logic               enc_err_i,
    output logic               rx_rst_o,
    output logic               ready_o,
    output logic               fail_o,
    output logic [RETRY_W-1:0] retry_cnt_o,
    output logic [RETRY_W-1:0] relock_cnt_o,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RESET     = 3'd1,
        ST_WAIT_SYNC = 3'd2,
        ST_CHECK     = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_READY     = 3'd5,
        ST_FAIL      = 3'd6,
        ST_UNUSED    = 3'd7
    } state_e;

    // One shared phase timer covers RESET hold, WAIT_SYNC timeout and SETTLE length.
    localparam int TMR_MAX0 = (RST_HOLD > LOCK_TIMEOUT) ? RST_HOLD : LOCK_TIMEOUT;
    localparam int TMR_MAX  = (TMR_MAX0 > SETTLE_CYC) ? TMR_MAX0 : SETTLE_CYC;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int WIN_W    = $clog2(ERR_WIN + 1);
    localparam int ERR_W    = $clog2(ERR_LIMIT + 1);

    localparam logic [TMR_W-1:0]   RST_LAST    = TMR_W'(RST_HOLD - 1);
    localparam logic [TMR_W-1:0]   LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0]   SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
    localparam logic [WIN_W-1:0]   WIN_LAST    = WIN_W'(ERR_WIN - 1);
    localparam logic [ERR_W-1:0]   ERR_LIM     = ERR_W'(ERR_LIMIT);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);
    localparam logic [RETRY_W-1:0] CNT_SAT     = '1;
    localparam logic [SLIDE_W-1:0] TGT_SLIDE   = SLIDE_W'(TARGET_SLIDE);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] relock_q, relock_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [ERR_W-1:0]   err_q, err_d;
    logic               rx_rst_q, ready_q, fail_q;

    logic               link_ok;
    logic               do_retry;
    logic [ERR_W-1:0]   err_inc;

    assign link_ok = serdes_ready_i & synced_i & (bitslide_i == TGT_SLIDE);
    assign err_inc = enc_err_i ? (err_q + ERR_W'(1)) : err_q;

    // Next-state and counter update; enable_i low overrides everything at the end.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        retry_d  = retry_q;
        relock_d = relock_q;
        win_d    = win_q;
        err_d    = err_q;
        do_retry = 1'b0;

        case (state_q)
            ST_IDLE: begin
                timer_d  = '0;
                retry_d  = '0;
                relock_d = '0;
                win_d    = '0;
                err_d    = '0;
                state_d  = ST_RESET;
            end
            ST_RESET: begin
                if (timer_q == RST_LAST) begin
                    state_d = ST_WAIT_SYNC;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_SYNC: begin
                // Sync is tested first so it wins over a coincident timeout.
                if (serdes_ready_i && synced_i) begin
                    state_d = ST_CHECK;
                    timer_d = '0;
                end else if (timer_q == LOCK_LAST) begin
                    do_retry = 1'b1;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_CHECK: begin
                if (bitslide_i == TGT_SLIDE) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    do_retry = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!link_ok || enc_err_i) begin
                    do_retry = 1'b1;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = ST_READY;
                    timer_d = '0;
                    win_d   = '0;
                    err_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_READY: begin
                // The error limit is checked before the window wrap so a last-cycle error still relocks.
                if (!link_ok || (err_inc == ERR_LIM)) begin
                    relock_d = (relock_q == CNT_SAT) ? relock_q : relock_q + RETRY_W'(1);
                    retry_d  = '0;
                    state_d  = ST_RESET;
                    timer_d  = '0;
                    win_d    = '0;
                    err_d    = '0;
                end else if (win_q == WIN_LAST) begin
                    win_d = '0;
                    err_d = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                    err_d = err_inc;
                end
            end
            ST_FAIL: begin
                retry_d = RETRY_MAX;
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase

        if (do_retry) begin
            timer_d = '0;
            if (retry_q == RETRY_MAX) begin
                state_d = ST_FAIL;
            end else begin
                retry_d = retry_q + RETRY_W'(1);
                state_d = ST_RESET;
            end
        end

        if (!enable_i) begin
            state_d  = ST_IDLE;
            timer_d  = '0;
            retry_d  = '0;
            relock_d = '0;
            win_d    = '0;
            err_d    = '0;
        end
    end

    // State, counters and registered outputs, all decoded from the next state so they move together.
    always_ff @(posedge rx_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            retry_q  <= '0;
            relock_q <= '0;
            win_q    <= '0;
            err_q    <= '0;
            rx_rst_q <= 1'b1;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            retry_q  <= retry_d;
            relock_q <= relock_d;
            win_q    <= win_d;
            err_q    <= err_d;
            rx_rst_q <= (state_d == ST_IDLE) || (state_d == ST_RESET);
            ready_q  <= (state_d == ST_READY);
            fail_q   <= (state_d == ST_FAIL);
        end
    end

    assign rx_rst_o     = rx_rst_q;
    assign ready_o      = ready_q;
    assign fail_o       = fail_q;
    assign retry_cnt_o  = retry_q;
    assign relock_cnt_o = relock_q;
    assign state_o      = state_q;

endmodule
